// File: rtl/nos_dac_serializer_mc.sv
// Multi-channel NOS DAC serializer: frame FIFO feeding per-channel MSB-first
// shift registers with a shared BCK and a latch-enable strobe.
module nos_dac_serializer_mc #(
  parameter int CHANNELS   = 2,
  parameter int IN_WIDTH   = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int BCK_DIV    = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [CHANNELS*IN_WIDTH-1:0]       in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               enable,
  input  logic                               bck_cont,
  input  logic [5:0]                         out_bits,
  input  logic                               clear_err,
  output logic                               bck,
  output logic [CHANNELS-1:0]                data,
  output logic                               le,
  output logic                               underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int FW = CHANNELS * IN_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = $clog2(2 * BCK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * BCK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCK_DIV);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [5:0]    NB_MIN   = 6'd8;
  localparam logic [5:0]    NB_MAX   = 6'(IN_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t              state_r;
  logic [DW-1:0]       div_r;
  logic [5:0]          bit_r;
  logic [5:0]          nb_r;
  logic [FW-1:0]       sh_r;
  logic [FW-1:0]       mem_r [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [LW-1:0]       level_r;
  logic                bck_r;
  logic [CHANNELS-1:0] data_r;
  logic                le_r;
  logic                underrun_r;
  logic                in_ready_r;

  logic                push_s;
  logic                start_s;
  logic                bit_end_s;
  logic [LW-1:0]       level_nxt_s;
  logic                bck_s;
  logic [CHANNELS-1:0] data_s;
  logic                le_s;

  function automatic logic [5:0] clamp_bits(input logic [5:0] b);
    if (b < NB_MIN) begin
      return NB_MIN;
    end else if (b > NB_MAX) begin
      return NB_MAX;
    end else begin
      return b;
    end
  endfunction

  // Handshake, frame-start decision, FIFO level update and next output values.
  always_comb begin
    push_s      = in_valid && in_ready_r;
    bit_end_s   = (div_r == DIV_LAST);
    start_s     = 1'b0;
    level_nxt_s = level_r;
    bck_s       = 1'b0;
    data_s      = '0;
    le_s        = 1'b0;
    // In continuous mode a frame may only start where the divider wraps.
    if ((state_r == ST_IDLE) && enable && (level_r != '0) && (!bck_cont || bit_end_s)) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
    if (push_s && !start_s) begin
      level_nxt_s = level_r + LW'(1);
    end else if (!push_s && start_s) begin
      level_nxt_s = level_r - LW'(1);
    end else begin
      level_nxt_s = level_r;
    end
    case (state_r)
      ST_SHIFT: begin
        bck_s = (div_r >= DIV_HALF);
        for (int k = 0; k < CHANNELS; k++) begin
          data_s[k] = sh_r[k*IN_WIDTH + IN_WIDTH - 1];
        end
      end
      ST_LATCH: begin
        le_s  = 1'b1;
        bck_s = bck_cont && (div_r >= DIV_HALF);
      end
      ST_IDLE: begin
        bck_s = bck_cont && (div_r >= DIV_HALF);
      end
      default: begin
        bck_s = 1'b0;
      end
    endcase
  end

  // Free-running BCK divider; a gated-mode frame start realigns it to phase 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r <= '0;
    end else if (start_s || bit_end_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DW'(1);
    end
  end

  // Frame storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // FIFO pointers and level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (start_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      level_r <= level_nxt_s;
    end
  end

  // Serializer FSM: IDLE -> SHIFT (nb bits) -> LATCH -> IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      bit_r   <= 6'd0;
      nb_r    <= 6'd0;
      sh_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r <= ST_SHIFT;
            sh_r    <= mem_r[rd_ptr_r];
            nb_r    <= clamp_bits(out_bits);
            bit_r   <= 6'd0;
          end
        end
        ST_SHIFT: begin
          if (bit_end_s) begin
            if (bit_r == nb_r - 6'd1) begin
              state_r <= ST_LATCH;
            end else begin
              bit_r <= bit_r + 6'd1;
              for (int k = 0; k < CHANNELS; k++) begin
                sh_r[k*IN_WIDTH +: IN_WIDTH] <= {sh_r[k*IN_WIDTH +: IN_WIDTH-1], 1'b0};
              end
            end
          end
        end
        ST_LATCH: begin
          if (bit_end_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky underrun: a set at LATCH end takes priority over clear_err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_r <= 1'b0;
    end else if ((state_r == ST_LATCH) && bit_end_s && enable && (level_r == '0)) begin
      underrun_r <= 1'b1;
    end else if (clear_err) begin
      underrun_r <= 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bck_r      <= 1'b0;
      data_r     <= '0;
      le_r       <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      bck_r      <= bck_s;
      data_r     <= data_s;
      le_r       <= le_s;
      in_ready_r <= (level_nxt_s < LVL_FULL);
    end
  end

  assign bck        = bck_r;
  assign data       = data_r;
  assign le         = le_r;
  assign underrun   = underrun_r;
  assign in_ready   = in_ready_r;
  assign fifo_level = level_r;

endmodule

// File: doc/nos_dac_serializer_mc.md
# nos_dac_serializer_mc

Parametrised multi-channel successor of the NOS DAC transceiver. It accepts parallel multi-channel sample frames over a valid/ready handshake and buffers them in a small FIFO. Each frame is serialised MSB-first onto one data line per channel, with a shared BCK and a latch-enable (LE) strobe for simultaneous-mode NOS DACs. It sits between the I2S deserializer and the DAC output mux in the MCLK domain. It adds run-time output bit depth, gated or continuous BCK, enable/drain control and sticky underrun detection.

## Interface
- CHANNELS, 2: number of output channels and data lines (1..8).
- IN_WIDTH, 32: width of each channel sample (16..32).
- FIFO_DEPTH, 4: frame FIFO depth (power of two, at least 2).
- BCK_DIV, 2: clk cycles per BCK half-period (at least 1).
- clk  in  1  master clock (MCLK); every flop is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  CHANNELS*IN_WIDTH  frame; channel k is in_data[k*IN_WIDTH +: IN_WIDTH]; for stereo, channel 1 (upper word) is left.
- in_valid  in  1  frame valid.
- in_ready  out  1  FIFO can accept a frame.
- enable  in  1  allows new frames to start.
- bck_cont  in  1  1 = BCK free-runs in every state; 0 = BCK toggles only in SHIFT.
- out_bits  in  6  serialised bits per sample. Sampled at frame start. Clamped to the range 8..IN_WIDTH.
- clear_err  in  1  clears underrun.
- bck  out  1  bit clock to the DAC.
- data  out  CHANNELS  serial data, one line per channel.
- le  out  1  latch enable.
- underrun  out  1  sticky underrun flag.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  number of frames held.

## Operation
- FIFO behaviour:
  - in_ready = (fifo_level < FIFO_DEPTH).
  - A push happens when in_valid && in_ready.
  - A pop happens on the IDLE→SHIFT transition.
  - A push and a pop in the same cycle leave the level unchanged.
  - A push while full is impossible, because in_ready is low.
  - The pointers wrap modulo FIFO_DEPTH.
- FSM states are IDLE, SHIFT and LATCH.
- IDLE:
  - data = 0 and le = 0.
  - Go to SHIFT when enable && fifo_level != 0. On that transition, pop the frame, load the per-channel shift registers, and latch nb = clamp(out_bits).
- SHIFT:
  - Send nb bits per channel, MSB first, taken from the top nb bits of each sample. The low IN_WIDTH-nb bits are truncated with no rounding.
  - Each bit has bck low for BCK_DIV cycles, then bck high for BCK_DIV cycles.
  - data changes only at the start of the low phase.
  - After bit nb's high phase, go to LATCH.
- LATCH:
  - le = 1 for 2*BCK_DIV cycles.
  - data = 0.
  - bck is low unless bck_cont = 1.
  - Then go to IDLE.
- bck_cont = 1: bck keeps the same 2*BCK_DIV-cycle period through IDLE and LATCH, using one free-running divider. Phase is not realigned; SHIFT starts at the divider's next low phase.
- enable deasserted mid-frame: the current frame finishes through LATCH. No new frame starts, and the FIFO keeps filling.
- underrun:
  - Set when LATCH ends with enable = 1 and fifo_level = 0.
  - Cleared by clear_err.
  - If set and clear happen in the same cycle, set wins.
- Reset mid-frame: the frame is abandoned immediately, the FIFO is emptied and the FSM returns to IDLE.

## Timing
- Reset values:
  - bck = 0, data = 0, le = 0, underrun = 0, fifo_level = 0.
  - in_ready = 1 once reset deasserts.
  - FSM is in IDLE and the divider is at 0.
- All outputs are registered.
- Latency with bck_cont = 0:
  - A push into an empty FIFO at edge t makes fifo_level = 1 after t.
  - IDLE pops at t+1.
  - MSB appears on data, with bck low, from edge t+2.
- Frame length is (nb+1)*2*BCK_DIV cycles.
- Back-to-back frames have exactly 1 IDLE cycle between the end of LATCH and the next SHIFT. With bck_cont = 1, the gap also waits for the divider's low phase.
- Sustained throughput requires the input frame rate to be no higher than 1/((nb+1)*2*BCK_DIV+1) frames per clk.

## Test plan
- Basic stereo frame: CHANNELS = 2, BCK_DIV = 1, out_bits = 16. Push in_data = {32'hA5A5_0000, 32'h0001_0000}.
  - data[1] shows 1010010110100101 over 16 bck periods and data[0] shows 0000000000000001.
  - le is high for 2 cycles.
  - The MSB appears 2 cycles after the push.
- Bit-depth clamp: out_bits = 4 gives 8 bck pulses; out_bits = 40 gives 32 pulses. out_bits changed mid-frame has no effect until the next frame.
- FIFO full: 5 pushes with FIFO_DEPTH = 4 and enable = 0.
  - in_ready drops after the 4th push and fifo_level = 4.
  - Raising enable drains the 4 frames in order, and in_ready rises 1 cycle after the first pop.
- Underrun: push 1 frame with enable = 1. underrun rises after the LATCH ends. Assert clear_err on a later cycle and underrun goes to 0. Assert clear_err coincident with a new underrun and the flag stays 1.
- BCK modes: with bck_cont = 0, bck is stuck at 0 in IDLE and LATCH. With bck_cont = 1, the bck period is 2*BCK_DIV = 4 cycles continuously across frames (BCK_DIV = 2).
- Reset mid-SHIFT at bit 7: bck, data and le go to 0 asynchronously, and fifo_level = 0. The next pushed frame starts again from its MSB.
